// File: rtl/serial_adder_unit.sv
// Multi-cycle add/subtract unit: a SLICE-bit full-adder ripple is reused over
// WIDTH/SLICE clocks, LSB first, with a start/busy/done handshake.
module serial_adder_unit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("serial_adder_unit: SLICE must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    logic             accept, running, last;
    logic [SLICE-1:0] s_slice;
    logic             slice_cout, carry_msb_in;
    logic [WIDTH-1:0] sum_full;

    assign running = (state_q == S_RUN);
    assign accept  = start && !running;
    assign last    = running && (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // carry_msb_in ends up as the carry into the top bit of the slice, which on
    // the final slice is the carry into bit WIDTH-1.
    always_comb begin : ripple
        logic cy;
        cy           = carry_q;
        s_slice      = '0;
        carry_msb_in = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            carry_msb_in = cy;
            s_slice[i]   = a_q[i] ^ b_q[i] ^ cy;
            cy           = (a_q[i] & b_q[i]) | (cy & (a_q[i] ^ b_q[i]));
        end
        slice_cout = cy;
    end

    if (SLICE < WIDTH) begin : g_acc
        logic [WIDTH-SLICE-1:0] acc_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset)       acc_q <= '0;
            else if (running) acc_q <= sum_full[WIDTH-1:SLICE];
        end

        assign sum_full = {s_slice, acc_q};
    end else begin : g_noacc
        assign sum_full = s_slice;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= x;
            b_q     <= y ^ {WIDTH{sub}};
            carry_q <= c_in ^ sub;
            cnt_q   <= '0;
        end else if (running) begin
            a_q     <= a_q >> SLICE;
            b_q     <= b_q >> SLICE;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                sum_q  <= sum_full;
                cout_q <= slice_cout;
                ovf_q  <= slice_cout ^ carry_msb_in;
            end
        end
    end

    assign busy     = running;
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Bench for serial_adder_unit at SLICE = 1, 4 and 8 (WIDTH = 8); expected
// results are queued on each start and compared whenever a unit raises done.
module tb_serial_adder_unit;

    logic            clock = 1'b0;
    logic            reset;
    logic [7:0]      x, y;
    logic            c_in, sub;
    logic [2:0]      st, bz, dn, co, ov;
    logic [2:0][7:0] sm;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         inst;
        logic [9:0] v;
    } exp_t;

    exp_t sbq[$];

    always #5 clock = ~clock;

    serial_adder_unit #(.WIDTH(8), .SLICE(1)) u_s1 (
        .clock(clock), .reset(reset), .start(st[0]), .x(x), .y(y), .c_in(c_in), .sub(sub),
        .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .c_out(co[0]), .overflow(ov[0]));
    serial_adder_unit #(.WIDTH(8), .SLICE(4)) u_s4 (
        .clock(clock), .reset(reset), .start(st[1]), .x(x), .y(y), .c_in(c_in), .sub(sub),
        .busy(bz[1]), .done(dn[1]), .sum(sm[1]), .c_out(co[1]), .overflow(ov[1]));
    serial_adder_unit #(.WIDTH(8), .SLICE(8)) u_s8 (
        .clock(clock), .reset(reset), .start(st[2]), .x(x), .y(y), .c_in(c_in), .sub(sub),
        .busy(bz[2]), .done(dn[2]), .sum(sm[2]), .c_out(co[2]), .overflow(ov[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: {overflow, c_out, sum}; overflow from operand/result signs.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic s);
        logic [7:0] bb;
        logic       cc, v;
        logic [8:0] f;
        bb = s ? ~b : b;
        cc = s ? ~ci : ci;
        f  = {1'b0, a} + {1'b0, bb} + {8'b0, cc};
        v  = (a[7] == bb[7]) && (f[7] != a[7]);
        return {v, f[8], f[7:0]};
    endfunction

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (dn[i]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_inst", 32'(i), 32'(e.inst));
                    chk("sum", {24'b0, sm[i]}, {24'b0, e.v[7:0]});
                    chk("c_out", {31'b0, co[i]}, {31'b0, e.v[8]});
                    chk("overflow", {31'b0, ov[i]}, {31'b0, e.v[9]});
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input int k, input logic [7:0] xv, input logic [7:0] yv,
                          input logic cv, input logic sv, input int nexp);
        int   bcnt, cyc;
        exp_t e;
        x = xv; y = yv; c_in = cv; sub = sv;
        st[k] = 1'b1;
        e.inst = k;
        e.v    = model(xv, yv, cv, sv);
        sbq.push_back(e);
        @(negedge clock);
        st[k] = 1'b0;
        bcnt = 0;
        cyc  = 0;
        while (!dn[k] && cyc < 40) begin
            if (bz[k]) bcnt++;
            cyc++;
            @(negedge clock);
        end
        chk("done_seen", {31'b0, dn[k]}, 32'd1);
        chk("busy_cycles", 32'(bcnt), 32'(nexp));
        chk("latency", 32'(cyc), 32'(nexp));
    endtask

    task automatic b2b(input int k, input int nops, input int nexp);
        @(negedge clock);
        for (int op = 0; op < nops; op++) begin
            run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), nexp);
        end
        @(negedge clock);
        chk("b2b_done_low", {31'b0, dn[k]}, 32'd0);
        chk("b2b_busy_low", {31'b0, bz[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ndone;
        reset = 1'b0;
        st = '0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {29'b0, bz}, 32'd0);
        chk("rst_done", {29'b0, dn}, 32'd0);
        chk("rst_sum", {8'b0, sm}, 32'd0);
        chk("rst_cout", {29'b0, co}, 32'd0);
        chk("rst_ovf", {29'b0, ov}, 32'd0);
        reset = 1'b1;

        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8);
        @(negedge clock); chk("done_one_cycle", {31'b0, dn[0]}, 32'd0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8);
        @(negedge clock); chk("done_one_cycle", {31'b0, dn[0]}, 32'd0);
        run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8);
        @(negedge clock);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8);
        @(negedge clock);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8);
        @(negedge clock);

        // Start pulsed while busy must be ignored.
        begin
            exp_t e;
            x = 8'h10; y = 8'h20; c_in = 1'b0; sub = 1'b0; st[0] = 1'b1;
            e.inst = 0; e.v = model(8'h10, 8'h20, 1'b0, 1'b0);
            sbq.push_back(e);
        end
        @(negedge clock);
        st[0] = 1'b0;
        chk("sum_stable_run", {24'b0, sm[0]}, 32'h7F);
        @(negedge clock);
        @(negedge clock);
        x = 8'hAA; st[0] = 1'b1;
        @(negedge clock);
        st[0] = 1'b0; x = 8'h00;
        chk("busy_ignore", {31'b0, bz[0]}, 32'd1);
        cyc = 0;
        while (!dn[0] && cyc < 40) begin cyc++; @(negedge clock); end
        chk("done_seen_ign", {31'b0, dn[0]}, 32'd1);
        repeat (4) @(negedge clock);
        chk("sum_held", {24'b0, sm[0]}, 32'h30);
        chk("idle_after_ign", {31'b0, bz[0]}, 32'd0);

        // Reset mid-run: abandoned, outputs cleared without a clock edge.
        x = 8'h03; y = 8'h04; st[0] = 1'b1;
        @(negedge clock);
        st[0] = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bz[0]}, 32'd0);
        chk("arst_done", {31'b0, dn[0]}, 32'd0);
        chk("arst_sum", {24'b0, sm[0]}, 32'd0);
        chk("arst_cout", {31'b0, co[0]}, 32'd0);
        chk("arst_ovf", {31'b0, ov[0]}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clock);
            if (dn[0]) ndone++;
        end
        chk("no_done_after_rst", 32'(ndone), 32'd0);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 8);
        @(negedge clock);

        b2b(1, 8, 2);
        b2b(2, 8, 1);

        repeat (2) @(negedge clock);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
